// File: rtl/prompt_sequencer.sv
// prompt_sequencer: Simon-style prompt generator, frame-timed sprite playback and key checker.
// Defining PROMPT_SEQ_TIMEOUT_EN adds a frame-counted input timeout while awaiting keys.
module prompt_sequencer #(
  parameter int         LEN_MAX        = 8,
  parameter int         ON_FRAMES      = 30,
  parameter int         OFF_FRAMES     = 10,
  parameter int         FRAME_LINE     = 480,
  parameter logic [7:0] SEED           = 8'hA5,
  parameter int         TIMEOUT_FRAMES = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       key_valid,
  input  logic [1:0] key_code,
  output logic       sprite_en,
  output logic [1:0] sprite_sel,
  output logic       busy,
  output logic       awaiting,
  output logic       done,
  output logic       pass,
  output logic [3:0] round_len
);
  localparam int IW = LEN_MAX > 1 ? $clog2(LEN_MAX) : 1;
  typedef enum logic [2:0] {IDLE, GEN, SHOW, GAP, AWAIT, DONE} state_t;
  state_t state, state_n;
  logic [7:0] lfsr, fcnt;
  logic [IW-1:0] idx;
  logic [1:0] mem [LEN_MAX];
  logic [1:0] sel_q;
  logic new_game, line_q, frame_tick, at_line, last, key_ok, ok, cnt_en;
  assign at_line = vCount == 10'(FRAME_LINE) && hCount == '0;
  assign last = 4'(idx) == round_len - 4'd1;
  assign key_ok = key_code == mem[idx];
  assign ok = key_valid && key_ok;
  assign sprite_sel = sprite_en ? mem[idx] : sel_q;
`ifdef PROMPT_SEQ_TIMEOUT_EN
  assign cnt_en = state inside {SHOW, GAP, AWAIT};
`else
  assign cnt_en = state inside {SHOW, GAP};
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start ? (new_game ? GEN : SHOW) : IDLE;
      GEN:   state_n = idx == IW'(LEN_MAX - 1) ? SHOW : GEN;
      SHOW:  state_n = frame_tick && fcnt == 8'(ON_FRAMES - 1) ? GAP : SHOW;
      GAP:   state_n = frame_tick && fcnt == 8'(OFF_FRAMES - 1) ? (last ? AWAIT : SHOW) : GAP;
`ifdef PROMPT_SEQ_TIMEOUT_EN
      AWAIT: state_n = key_valid ? (!key_ok || last ? DONE : AWAIT)
                     : (frame_tick && fcnt == 8'(TIMEOUT_FRAMES - 1) ? DONE : AWAIT);
`else
      AWAIT: state_n = key_valid && (!key_ok || last) ? DONE : AWAIT;
`endif
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lfsr       <= SEED;
      fcnt       <= '0;
      idx        <= '0;
      new_game   <= 1'b1;
      line_q     <= 1'b0;
      frame_tick <= 1'b0;
      pass       <= 1'b0;
      round_len  <= 4'd1;
      sprite_en  <= 1'b0;
      busy       <= 1'b0;
      awaiting   <= 1'b0;
      done       <= 1'b0;
      sel_q      <= '0;
    end else begin
      lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      line_q     <= at_line;
      frame_tick <= at_line && !line_q;
      state      <= state_n;
      // a tick landing on a state-entry edge is dropped: the first counted tick follows entry
      fcnt       <= state_n != state || (state == AWAIT && key_valid) ? '0 : fcnt + 8'(cnt_en && frame_tick);
      sprite_en  <= state_n == SHOW;
      busy       <= state_n != IDLE;
      awaiting   <= state_n == AWAIT;
      done       <= state_n == DONE;
      if (sprite_en) sel_q <= mem[idx];
      if (state == IDLE && start) begin
        idx  <= '0;
        pass <= 1'b0;
      end
      if (state == GEN) begin
        idx <= state_n == SHOW ? '0 : idx + 1'b1;
        if (state_n == SHOW) new_game <= 1'b0;
      end
      if (state == GAP && state_n != GAP) idx <= last ? '0 : idx + 1'b1;
      if (state == AWAIT && ok && !last) idx <= idx + 1'b1;
      if (state == AWAIT && state_n == DONE) begin
        pass      <= ok;
        round_len <= ok ? (round_len == 4'(LEN_MAX) ? round_len : round_len + 4'd1) : 4'd1;
        if (!ok) new_game <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (state == GEN) mem[idx] <= lfsr[1:0];
endmodule

// File: tb/tb_prompt_sequencer.sv
// tb_prompt_sequencer: directed rounds with a queue scoreboard for prompt playback and round results.
module tb_prompt_sequencer;
  logic clk = 0, rst = 0, start = 0, key_valid = 0;
  logic [1:0] key_code = 0;
  logic [9:0] hCount = 0, vCount = 0;
  logic sprite_en, busy, awaiting, done, pass;
  logic [1:0] sprite_sel;
  logic [3:0] round_len;

  prompt_sequencer #(.LEN_MAX(4), .ON_FRAMES(2), .OFF_FRAMES(1), .FRAME_LINE(480),
                     .SEED(8'hA5), .TIMEOUT_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .hCount(hCount), .vCount(vCount),
    .key_valid(key_valid), .key_code(key_code), .sprite_en(sprite_en), .sprite_sel(sprite_sel),
    .busy(busy), .awaiting(awaiting), .done(done), .pass(pass), .round_len(round_len));

  always #5 clk = ~clk;

  typedef struct {logic [1:0] sel; bit first; int gen;} show_t;
  typedef struct {bit pass; logic [3:0] len;} done_t;
  show_t q_show[$];
  done_t q_done[$];
  int n_chk = 0, n_fail = 0;
  int cur_len = 1;
  bit ng = 1;
  logic [1:0] exp_mem [4];
  logic [7:0] m_lfsr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference LFSR for x^8+x^6+x^5+x^4+1, free-running from reset like the sequencer's
  always @(posedge clk or negedge rst)
    if (!rst) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  // frame line held for 4 clocks every 20 clocks
  initial begin
    int c = 0;
    forever begin
      @(negedge clk);
      c = c == 19 ? 0 : c + 1;
      vCount = c < 4 ? 10'd480 : 10'd7;
      hCount = c < 4 ? 10'd0 : 10'd5;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // monitor: measures playback and round results and compares against queued expectations
  int since_busy = 0, since_fall = 0, hi_len = 0, mgen = 0, rise_gap = 0;
  logic pen = 0, pbusy = 0, paw = 0;
  logic [1:0] msel = 0;
  always @(negedge clk) begin
    show_t es;
    done_t ed;
    if (!rst) begin
      pen = 0; pbusy = 0; paw = 0; since_fall = 0;
    end else begin
      if (busy && !pbusy) since_busy = 0;
      if (sprite_en && !pen) begin
        msel = sprite_sel; mgen = since_busy; hi_len = 0; rise_gap = since_fall;
      end
      if (sprite_en) begin
        hi_len++;
        chk("sel_stable", sprite_sel, msel);
      end
      if (!sprite_en && pen) begin
        if (q_show.size() == 0) chk("show_unexpected", 1, 0);
        else begin
          es = q_show.pop_front();
          chk("show_sel", msel, es.sel);
          if (es.first) begin
            chk("gen_cycles", mgen, es.gen);
            chk("first_show_len_in_21_40", hi_len >= 21 && hi_len <= 40, 1);
          end else begin
            chk("show_len", hi_len, 40);
            chk("gap_len", rise_gap, 20);
          end
        end
        since_fall = 0;
      end
      if (awaiting && !paw) chk("await_gap", since_fall, 20);
      if (done) begin
        if (q_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          ed = q_done.pop_front();
          chk("pass", pass, ed.pass);
          chk("round_len", round_len, ed.len);
        end
      end
      since_busy++; since_fall++;
      pen = sprite_en; pbusy = busy; paw = awaiting;
    end
  end

  task automatic wait_await;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (awaiting) return;
    end
    chk("await_timeout", 0, 1);
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_show;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sprite_en) return;
    end
    chk("show_timeout", 0, 1);
  endtask

  task automatic press(input logic [1:0] k);
    @(negedge clk); key_valid = 1; key_code = k;
    @(negedge clk); key_valid = 0;
  endtask

  // mem[i] is the LFSR value the sequencer holds on the i-th GEN cycle
  task automatic start_round(input bit gen);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    if (gen)
      for (int i = 0; i < 4; i++) begin
        if (i != 0) @(negedge clk);
        exp_mem[i] = m_lfsr[1:0];
      end
  endtask

  task automatic play(input int wrong_at, input bit noise, input bit hold);
    bit gen, p;
    int n, elen;
    gen = ng;
    start_round(gen);
    ng = 0;
    for (int i = 0; i < cur_len; i++) q_show.push_back('{exp_mem[i], i == 0, gen ? 4 : 0});
    if (noise) begin
      wait_show;
      @(negedge clk); start = 1; key_valid = 1; key_code = exp_mem[0] + 2'd1;
      @(negedge clk); start = 0; key_valid = 0;
    end
    wait_await;
    if (hold) begin
`ifdef PROMPT_SEQ_TIMEOUT_EN
      q_done.push_back('{1'b0, 4'd1});
      cur_len = 1; ng = 1;
      wait_idle;
      return;
`else
      repeat (2000) @(negedge clk);
      chk("no_timeout_awaiting", awaiting, 1);
`endif
    end
    p = wrong_at < 0;
    n = p ? cur_len : wrong_at + 1;
    elen = p ? (cur_len == 4 ? 4 : cur_len + 1) : 1;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) q_done.push_back('{p, 4'(elen)});
      press(i == wrong_at ? exp_mem[i] + 2'd1 : exp_mem[i]);
    end
    cur_len = elen;
    if (!p) ng = 1;
    wait_idle;
  endtask

  task automatic reset_mid;
    start_round(ng);
    wait_show;
    @(negedge clk); rst = 0;
    @(negedge clk);
    chk("rst_sprite_en", sprite_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_round_len", round_len, 1);
    chk("rst_done", done, 0);
    chk("rst_awaiting", awaiting, 0);
    rst = 1;
    cur_len = 1; ng = 1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_sprite_en", sprite_en, 0);
    chk("reset_sprite_sel", sprite_sel, 0);
    chk("reset_busy", busy, 0);
    chk("reset_awaiting", awaiting, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_round_len", round_len, 1);
    rst = 1;
    repeat (5) @(negedge clk);
    play(-1, 1, 0);
    play(1, 0, 0);
    play(-1, 0, 0);
    reset_mid();
    play(-1, 0, 1);
    while (cur_len < 4) play(-1, 0, 0);
    play(-1, 0, 0);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q_show.size() + q_done.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
